tetris_game_fsm: RTL



---
 rtl/tetris_game_fsm.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/tetris_game_fsm.sv
// Tetris game-state controller: board register, IDLE/PLAY/CLEAR/PAUSE/OVER modes, row compaction, lines/level; TETRIS_LINE_SCORE_EN adds scoring.
// Latency: lock -> spawn in BOARD_H+k+1 cycles; piece logic must hold while busy, inputs other than reset are ignored in CLEAR.
`timescale 1ns/1ps
module tetris_game_fsm #(
  parameter int BOARD_W         = 10,
  parameter int BOARD_H         = 20,
  parameter int LINES_PER_LEVEL = 10,
  parameter int MAX_LEVEL       = 3,
  parameter int LEVEL_W         = 2,
  parameter int LINE_W          = 10,
  parameter int SCORE_W         = 16
) (
  input  logic                       clk_100MHz,
  input  logic                       sw_rst_n,
  input  logic                       pause_p,
  input  logic                       lock_req,
  input  logic [BOARD_W*BOARD_H-1:0] merged_board,
  input  logic                       spawn_overlap,
  output logic [BOARD_W*BOARD_H-1:0] stacked_block,
  output logic [1:0]                 mode,
  output logic                       spawn,
  output logic                       busy,
  output logic [LINE_W-1:0]          lines,
  output logic [LEVEL_W-1:0]         level,
  output logic [SCORE_W-1:0]         score
);

  localparam int ROW_W = $clog2(BOARD_H);
  localparam int K_W   = $clog2(BOARD_H + 1);
  localparam logic [ROW_W-1:0] ROW_TOP = ROW_W'(BOARD_H - 1);

  typedef enum logic [2:0] {S_IDLE, S_PLAY, S_CLEAR, S_PAUSE, S_OVER} state_t;

  state_t state, state_nxt;

  logic [BOARD_W-1:0] rows [BOARD_H];
  logic [ROW_W-1:0]   src, dst;
  logic               src_vld;
  logic [K_W-1:0]     clr_cnt;
  logic               spawn_chk;

  logic [BOARD_W-1:0] src_row;
  logic               row_full;
  logic               clear_done;
  logic               overlap_hit;
  logic               start;
  logic               lock_acc;

  logic [LINE_W:0]    lines_sum;
  logic [LINE_W-1:0]  lines_new;
  logic [LINE_W-1:0]  lvl_raw;
  logic [LEVEL_W-1:0] level_new;

  always_comb begin
    src_row     = rows[src];
    row_full    = src_vld && (&src_row);
    clear_done  = (state == S_CLEAR) && !row_full && (dst == '0);
    overlap_hit = spawn_chk && spawn_overlap;
    state_nxt   = state;
    case (state)
      S_IDLE:  if (pause_p) state_nxt = S_PLAY;
      S_PLAY: begin
        if (overlap_hit)   state_nxt = S_OVER;
        else if (lock_req) state_nxt = S_CLEAR;
        else if (pause_p)  state_nxt = S_PAUSE;
      end
      S_CLEAR: if (clear_done) state_nxt = S_PLAY;
      S_PAUSE: begin
        if (overlap_hit)  state_nxt = S_OVER;
        else if (pause_p) state_nxt = S_PLAY;
      end
      S_OVER:  if (pause_p) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign start    = (state == S_IDLE) && pause_p;
  assign lock_acc = (state == S_PLAY) && (state_nxt == S_CLEAR);

  always_ff @(posedge clk_100MHz or negedge sw_rst_n) begin
    if (!sw_rst_n) state <= S_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    mode = 2'd0;
    case (state)
      S_PLAY, S_CLEAR: mode = 2'd1;
      S_PAUSE:         mode = 2'd2;
      S_OVER:          mode = 2'd3;
      default:         mode = 2'd0;
    endcase
  end

  assign busy = (state == S_CLEAR);

  genvar gr;
  generate
    for (gr = 0; gr < BOARD_H; gr++) begin : g_flat
      assign stacked_block[gr*BOARD_W +: BOARD_W] = rows[gr];
    end
  endgenerate

  always_comb begin
    lines_sum = {1'b0, lines} + (LINE_W+1)'(clr_cnt);
    lines_new = lines_sum[LINE_W] ? '1 : lines_sum[LINE_W-1:0];
    lvl_raw   = lines_new / LINE_W'(LINES_PER_LEVEL);
    level_new = (lvl_raw >= LINE_W'(MAX_LEVEL)) ? LEVEL_W'(MAX_LEVEL) : lvl_raw[LEVEL_W-1:0];
  end

  // Compaction: s skips full rows, d trails it and receives surviving rows bottom-up.
  always_ff @(posedge clk_100MHz or negedge sw_rst_n) begin
    if (!sw_rst_n) begin
      for (int r = 0; r < BOARD_H; r++) rows[r] <= '0;
      src       <= '0;
      dst       <= '0;
      src_vld   <= 1'b0;
      clr_cnt   <= '0;
      spawn     <= 1'b0;
      spawn_chk <= 1'b0;
      lines     <= '0;
      level     <= '0;
    end else begin
      spawn     <= start || clear_done;
      spawn_chk <= spawn;
      if (start) begin
        for (int r = 0; r < BOARD_H; r++) rows[r] <= '0;
        lines <= '0;
        level <= '0;
      end else if (lock_acc) begin
        for (int r = 0; r < BOARD_H; r++) rows[r] <= merged_board[r*BOARD_W +: BOARD_W];
        src     <= ROW_TOP;
        dst     <= ROW_TOP;
        src_vld <= 1'b1;
        clr_cnt <= '0;
      end else if (state == S_CLEAR) begin
        if (row_full) begin
          clr_cnt <= clr_cnt + K_W'(1);
        end else begin
          rows[dst] <= src_vld ? src_row : '0;
          if (dst != '0) dst <= dst - ROW_W'(1);
        end
        if (src_vld) begin
          if (src == '0) src_vld <= 1'b0;
          else           src     <= src - ROW_W'(1);
        end
        if (clear_done) begin
          lines <= lines_new;
          level <= level_new;
        end
      end
    end
  end

`ifdef TETRIS_LINE_SCORE_EN
  logic [3:0]         weight;
  logic [LEVEL_W+4:0] score_add;
  logic [SCORE_W:0]   score_sum;

  always_comb begin
    case (clr_cnt)
      K_W'(0): weight = 4'd0;
      K_W'(1): weight = 4'd1;
      K_W'(2): weight = 4'd3;
      K_W'(3): weight = 4'd5;
      default: weight = 4'd8;
    endcase
    // Uses the level in force before this clear is credited.
    score_add = (LEVEL_W+5)'(weight) * ((LEVEL_W+5)'(level) + (LEVEL_W+5)'(1));
    score_sum = {1'b0, score} + (SCORE_W+1)'(score_add);
  end

  always_ff @(posedge clk_100MHz or negedge sw_rst_n) begin
    if (!sw_rst_n)       score <= '0;
    else if (start)      score <= '0;
    else if (clear_done) score <= score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
  end
`else
  assign score = '0;
`endif

endmodule
